// File: rtl/lsu_ext_req_queue_if.sv
// rtl/lsu_ext_req_queue_if.sv - LSU/bus-side signal bundle for the external request queue.
// The slave modport is the queue; the master modport is the LSU pipeline plus bus unit.
interface lsu_ext_req_queue_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
);
  logic             req_valid_dc3;
  logic             req_fault_dc3;
  logic [31:0]      req_addr_dc3;
  logic             req_write_dc3;
  logic [1:0]       req_size_dc3;
  logic [31:0]      req_wdata_dc3;
  logic             req_sideeffect_dc3;
  logic             flush_dc3;
  logic             q_full;
  logic             q_empty;
  logic             bus_req_valid;
  logic             bus_req_ready;
  logic [31:0]      bus_req_addr;
  logic             bus_req_write;
  logic [1:0]       bus_req_size;
  logic [31:0]      bus_req_wdata;
  logic [IDX_W-1:0] bus_req_tag;
  logic             bus_rsp_valid;
  logic [IDX_W-1:0] bus_rsp_tag;
  logic [31:0]      bus_rsp_data;
  logic             bus_rsp_err;
  logic             ld_rsp_valid;
  logic [31:0]      ld_rsp_data;
  logic             ld_rsp_err;
  logic             store_err;
  logic             rsp_proto_err;

  modport slave (
    input  req_valid_dc3, req_fault_dc3, req_addr_dc3, req_write_dc3, req_size_dc3,
           req_wdata_dc3, req_sideeffect_dc3, flush_dc3, bus_req_ready,
           bus_rsp_valid, bus_rsp_tag, bus_rsp_data, bus_rsp_err,
    output q_full, q_empty, bus_req_valid, bus_req_addr, bus_req_write, bus_req_size,
           bus_req_wdata, bus_req_tag, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
           store_err, rsp_proto_err
  );

  modport master (
    output req_valid_dc3, req_fault_dc3, req_addr_dc3, req_write_dc3, req_size_dc3,
           req_wdata_dc3, req_sideeffect_dc3, flush_dc3, bus_req_ready,
           bus_rsp_valid, bus_rsp_tag, bus_rsp_data, bus_rsp_err,
    input  q_full, q_empty, bus_req_valid, bus_req_addr, bus_req_write, bus_req_size,
           bus_req_wdata, bus_req_tag, ld_rsp_valid, ld_rsp_data, ld_rsp_err,
           store_err, rsp_proto_err
  );
endinterface

// File: rtl/lsu_ext_req_queue.sv
// rtl/lsu_ext_req_queue.sv - in-order external LSU request queue with side-effect ordering.
// Three wrap-bit pointers split the ring into outstanding (rd..iss) and unissued (iss..wr).
module lsu_ext_req_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst_l,
  lsu_ext_req_queue_if.slave  io
);
  localparam int PW = IDX_W + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] iss_ptr_q, iss_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          sfx_busy_q, sfx_busy_d;
  logic          q_full_q, q_empty_q;
  logic          ld_rsp_valid_q, ld_rsp_err_q, store_err_q, rsp_proto_err_q;
  logic [31:0]   ld_rsp_data_q;

  logic [31:0]   addr_mem  [DEPTH];
  logic [31:0]   wdata_mem [DEPTH];
  logic [1:0]    size_mem  [DEPTH];
  logic          write_mem [DEPTH];
  logic          sfx_mem   [DEPTH];

  logic [IDX_W-1:0] wr_idx, iss_idx, rd_idx;
  logic [PW-1:0]    outstanding, count_d;
  logic             has_unissued, eligible, push, issue, rsp_ok, rsp_is_store;

  assign wr_idx       = wr_ptr_q[IDX_W-1:0];
  assign iss_idx      = iss_ptr_q[IDX_W-1:0];
  assign rd_idx       = rd_ptr_q[IDX_W-1:0];
  assign outstanding  = iss_ptr_q - rd_ptr_q;
  assign has_unissued = (iss_ptr_q != wr_ptr_q);

  // A side-effect entry waits for an empty bus; others only wait behind a side-effect entry.
  assign eligible = has_unissued &&
                    (sfx_mem[iss_idx] ? (outstanding == '0) : !sfx_busy_q);

  assign push  = io.req_valid_dc3 && !io.req_fault_dc3 && !q_full_q && !io.flush_dc3;
  assign issue = eligible && io.bus_req_ready;

  assign rsp_ok       = io.bus_rsp_valid && (io.bus_rsp_tag == rd_idx) && (outstanding != '0);
  assign rsp_is_store = write_mem[rd_idx];

  assign io.bus_req_valid = eligible;
  assign io.bus_req_addr  = addr_mem[iss_idx];
  assign io.bus_req_write = write_mem[iss_idx];
  assign io.bus_req_size  = size_mem[iss_idx];
  assign io.bus_req_wdata = wdata_mem[iss_idx];
  assign io.bus_req_tag   = iss_idx;

  assign io.q_full        = q_full_q;
  assign io.q_empty       = q_empty_q;
  assign io.ld_rsp_valid  = ld_rsp_valid_q;
  assign io.ld_rsp_data   = ld_rsp_data_q;
  assign io.ld_rsp_err    = ld_rsp_err_q;
  assign io.store_err     = store_err_q;
  assign io.rsp_proto_err = rsp_proto_err_q;

  always_comb begin
    iss_ptr_d  = iss_ptr_q + (issue ? PW'(1) : PW'(0));
    rd_ptr_d   = rd_ptr_q + (rsp_ok ? PW'(1) : PW'(0));
    sfx_busy_d = sfx_busy_q;
    if (rsp_ok)
      sfx_busy_d = 1'b0;
    if (issue && sfx_mem[iss_idx])
      sfx_busy_d = 1'b1;
    // Flush keeps only the entry already presented to the bus, issued this cycle or not.
    if (io.flush_dc3)
      wr_ptr_d = iss_ptr_q + (eligible ? PW'(1) : PW'(0));
    else
      wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q        <= '0;
      iss_ptr_q       <= '0;
      rd_ptr_q        <= '0;
      sfx_busy_q      <= 1'b0;
      q_full_q        <= 1'b0;
      q_empty_q       <= 1'b1;
      ld_rsp_valid_q  <= 1'b0;
      ld_rsp_data_q   <= '0;
      ld_rsp_err_q    <= 1'b0;
      store_err_q     <= 1'b0;
      rsp_proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      iss_ptr_q       <= iss_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      sfx_busy_q      <= sfx_busy_d;
      q_full_q        <= (count_d == PW'(DEPTH));
      q_empty_q       <= (count_d == '0);
      ld_rsp_valid_q  <= rsp_ok && !rsp_is_store;
      ld_rsp_err_q    <= rsp_ok && !rsp_is_store && io.bus_rsp_err;
      store_err_q     <= rsp_ok && rsp_is_store && io.bus_rsp_err;
      rsp_proto_err_q <= io.bus_rsp_valid && !rsp_ok;
      if (rsp_ok && !rsp_is_store)
        ld_rsp_data_q <= io.bus_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx]  <= io.req_addr_dc3;
      wdata_mem[wr_idx] <= io.req_wdata_dc3;
      size_mem[wr_idx]  <= io.req_size_dc3;
      write_mem[wr_idx] <= io.req_write_dc3;
      sfx_mem[wr_idx]   <= io.req_sideeffect_dc3;
    end
  end
endmodule
